fsm_step_sequencer: RTL and testbench
=====================================

// Module: fsm_step_sequencer
// PURPOSE
//  Sequencer for the two-flop (D + JK) Mealy/Moore FSM datapath (state y1/y2, output z=y1&y2).
//  Replaces the free-running slow clock with a one-cycle step enable on the system clock.
//  Per step: applies one bit of a loaded x-pattern, logs z for that step, finishes after N steps.
//  Auto mode paces steps from an internal divider; manual mode steps on a button pulse.
//  Sits between board I/O (switches/buttons/LEDs) and the FSM flops, which all run on clk.
// PARAMETERS
//  N    8   pattern length / number of steps per run (>=2)
//  DIV  4   system-clock cycles per auto step (>=2; 50_000_000 on board, 4 in sim)
// PORTS
//  clk       in   1        system clock; all logic on rising edge
//  clr       in   1        synchronous active-high reset
//  start     in   1        level/pulse; a run is accepted only in IDLE
//  mode      in   1        0 = auto (divider-paced), 1 = manual (step_req-paced); sampled at start
//  step_req  in   1        manual step pulse (pre-debounced, 1 cycle)
//  pattern   in   N        x bits for the run, LSB applied first; sampled at start
//  z         in   1        FSM output for the current state
//  x         out  1        current pattern bit to the FSM next-state logic
//  step_en   out  1        1-cycle clock enable to the FSM flops
//  busy      out  1        run in progress
//  done      out  1        1-cycle pulse: run complete
//  z_log     out  N        z_log[i] = z sampled at step i
// BEHAVIOUR
//  Reset: state IDLE; x=0, step_en=0, busy=0, done=0, z_log=0, divider=0, step count=0.
//   clr has priority over every other input, including mid-run: the run is dropped and no done is
//   issued. clr does not reset the FSM flops; the FSM has its own clr.
//  States: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: if start=1 then latch pattern into shreg, latch mode, clear divider/count/z_log, go RUN.
//   RUN: busy=1; x=shreg[0].
//     Auto: the divider counts 0..DIV-1 and wraps. step_en=1 in the cycle the divider is DIV-1.
//       step_req is ignored.
//     Manual: step_en=1 in the cycle step_req=1. The divider is held at 0.
//     In a step_en cycle: z_log[count] <= z (pre-edge state); shreg >>= 1; count++.
//       The FSM flops load on the same edge.
//     When count==N-1 and step_en=1, go DONE.
//   DONE: done=1 and busy=0 for exactly 1 cycle, then IDLE. z_log holds until the next accepted start.
//  Timing: with start accepted at cycle c, busy=1 for cycles c+1..c+N*DIV (auto mode).
//   step_en fires at c+k*DIV for k=1..N; done fires at c+N*DIV+1.
//  Edge cases:
//   - start during RUN/DONE is ignored; pattern/mode changes mid-run have no effect.
//   - step_req in IDLE/DONE, or in auto mode, is ignored and never queued.
//   - Back-to-back: start held high re-arms in the IDLE cycle after done.
//   - x is 0 outside RUN; step_en is never asserted outside RUN.
//  Widths: count is $clog2(N) bits; divider is $clog2(DIV) bits. No overflow is possible by construction.
// STRUCTURE
//  Package fsm_seq_pkg: typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t; default DIV constants.
//  Sub-module: step_tick_gen (clk, clr, en, tick): the divider, reusable in place of the slow clock.
//  Top level: state register, shreg, count, z_log, step_en mux (auto tick vs step_req).
// TESTING (N=4, DIV=4, FSM model attached to x/step_en/z)
//  1. clr 2 cycles -> all outputs 0, state IDLE; step_req pulses produce no step_en.
//  2. auto, pattern=4'b1011, start at c -> step_en at c+4/8/12/16 with x=1,1,0,1;
//     done at c+17; z_log matches the golden FSM model.
//  3. manual, pattern=4'b0110 -> step_en only on step_req pulses, spaced 3,10,1,5 cycles;
//     done the cycle after the 4th; busy=1 throughout.
//  4. start re-pulsed at c+6 with pattern=4'b0000 -> no effect; the run completes with 4'b1011.
//  5. clr at c+9 (mid-run) -> next cycle busy=0, z_log=0, no done; a fresh start runs a full 4 steps.
//  6. start held high -> done at c+17, a new run is accepted at c+18, second done at c+35.

Source files
------------

// File: rtl/fsm_step_sequencer_pkg.sv
// Shared types and constants for the FSM step sequencer.
// The sequencer replaces the slow clock with a one-cycle step enable.
package fsm_seq_pkg;

  localparam int unsigned N_DEFAULT   = 8;
  localparam int unsigned DIV_SIM     = 4;
  localparam int unsigned DIV_BOARD   = 50_000_000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/fsm_step_sequencer_if.sv
// Board-side / FSM-side signal bundle of the step sequencer.
// The master side drives run control and FSM output z; the slave is the sequencer.
interface fsm_step_sequencer_if
  import fsm_seq_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
);

  logic         start;
  logic         mode;
  logic         step_req;
  logic [N-1:0] pattern;
  logic         z;
  logic         x;
  logic         step_en;
  logic         busy;
  logic         done;
  logic [N-1:0] z_log;

  modport master (
    output start, mode, step_req, pattern, z,
    input  x, step_en, busy, done, z_log
  );

  modport slave (
    input  start, mode, step_req, pattern, z,
    output x, step_en, busy, done, z_log
  );

endinterface

// File: rtl/fsm_step_sequencer_tick.sv
// Step divider: tick pulses once every DIV enabled cycles; held at 0 while disabled.
module step_tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clr || !en) begin
      cnt <= '0;
    end else if (cnt == W'(DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = en && (cnt == W'(DIV - 1));

endmodule

// File: rtl/fsm_step_sequencer.sv
// Step sequencer for the D+JK FSM: feeds one pattern bit per step, logs z per step,
// and paces steps from the internal divider (auto) or from step_req (manual).
module fsm_step_sequencer
  import fsm_seq_pkg::*;
#(
  parameter int unsigned N   = N_DEFAULT,
  parameter int unsigned DIV = DIV_SIM
) (
  input  logic                 clk,
  input  logic                 clr,
  fsm_step_sequencer_if.slave  bus
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  seq_state_t   state;
  seq_state_t   state_nxt;
  logic [N-1:0] shreg;
  logic [N-1:0] z_log_q;
  logic [CW-1:0] count;
  logic         manual;
  logic         tick_en;
  logic         tick;
  logic         step;

  assign tick_en = (state == RUN) && !manual;

  step_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .clr  (clr),
    .en   (tick_en),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Step source mux and run sequencing; the last step hands over to DONE.
  always_comb begin
    state_nxt = state;
    step      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) state_nxt = RUN;
      end
      RUN: begin
        step = manual ? bus.step_req : tick;
        if (step && (count == CW'(N - 1))) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // z is sampled before the FSM flops update on the same edge.
  always_ff @(posedge clk) begin
    if (clr) begin
      shreg   <= '0;
      z_log_q <= '0;
      count   <= '0;
      manual  <= 1'b0;
    end else if ((state == IDLE) && bus.start) begin
      shreg   <= bus.pattern;
      manual  <= bus.mode;
      z_log_q <= '0;
      count   <= '0;
    end else if (step) begin
      z_log_q[count] <= bus.z;
      shreg          <= shreg >> 1;
      count          <= count + CW'(1);
    end
  end

  assign bus.x       = (state == RUN) && shreg[0];
  assign bus.step_en = step;
  assign bus.busy    = (state == RUN);
  assign bus.done    = (state == DONE);
  assign bus.z_log   = z_log_q;

endmodule

// File: tb/tb_fsm_step_sequencer.sv
// Directed bench for fsm_step_sequencer with a D+JK FSM model hung on x/step_en/z.
module tb_fsm_step_sequencer;
  import fsm_seq_pkg::*;

  localparam int unsigned N   = 4;
  localparam int unsigned DIV = 4;

  logic clk;
  logic clr;
  logic fsm_clr;
  logic y1, y2;
  logic my1, my2;
  int   total;
  int   bad;

  fsm_step_sequencer_if #(.N(N)) bus ();

  fsm_step_sequencer #(.N(N), .DIV(DIV)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FSM under control: y1 is a D flop, y2 a JK flop with J = x&y1, K = ~x.
  always @(posedge clk) begin
    if (fsm_clr) begin
      y1 <= 1'b0;
      y2 <= 1'b0;
    end else if (bus.step_en) begin
      y1 <= bus.x ^ y2;
      y2 <= (bus.x & y1 & ~y2) | (bus.x & y2);
    end
  end
  assign bus.z = y1 & y2;

  // Reference: returns {y1, y2, z_log} after 'steps' steps from (a1, a2).
  function automatic logic [5:0] model(input logic [3:0] pat, input int steps,
                                       input logic a1, input logic a2);
    logic [3:0] zl;
    logic b1, b2, xb, n1, n2;
    zl = 4'b0000;
    b1 = a1;
    b2 = a2;
    for (int i = 0; i < steps; i++) begin
      xb    = pat[i];
      zl[i] = b1 & b2;
      n1    = xb ^ b2;
      n2    = (xb & b1 & ~b2) | (xb & b2);
      b1    = n1;
      b2    = n2;
    end
    return {b1, b2, zl};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fsm_reset();
    fsm_clr = 1'b1;
    cyc();
    fsm_clr = 1'b0;
    my1 = 1'b0;
    my2 = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    bus.step_req = 1'b1;
    cyc();
    cyc();
    #1;
    total++;
    if ({bus.x, bus.step_en, bus.busy, bus.done} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_outs got=%b want=0000", {bus.x, bus.step_en, bus.busy, bus.done});
    end
    total++;
    if (bus.z_log !== 4'b0000) begin
      bad++;
      $display("FAIL reset_zlog got=%b want=0000", bus.z_log);
    end
    clr = 1'b0;
    for (int j = 0; j < 3; j++) begin
      cyc();
      bus.step_req = (j != 1);
      #1;
      total++;
      if (bus.step_en !== 1'b0 || bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL idle_step_req cyc=%0d step_en=%b busy=%b want 0 0", j, bus.step_en, bus.busy);
      end
    end
    bus.step_req = 1'b0;
    cyc();
  endtask

  task automatic test_auto();
    logic [3:0] pat;
    logic [5:0] m;
    logic exp_step, exp_busy, exp_done, exp_x;
    int k;
    pat = 4'b1011;
    fsm_reset();
    m = model(pat, 4, my1, my2);
    bus.pattern = pat;
    bus.mode    = 1'b0;
    bus.start   = 1'b1;
    cyc();
    bus.start   = 1'b0;
    bus.pattern = 4'b0000;
    for (int j = 1; j <= 18; j++) begin
      bus.step_req = (j == 5) || (j == 6);
      #1;
      exp_busy = (j <= 16);
      exp_step = exp_busy && (j % 4 == 0);
      exp_done = (j == 17);
      k        = exp_busy ? (j - 1) / 4 : 0;
      exp_x    = exp_busy ? pat[k] : 1'b0;
      total++;
      if ({bus.step_en, bus.busy, bus.done, bus.x} !== {exp_step, exp_busy, exp_done, exp_x}) begin
        bad++;
        $display("FAIL auto cyc=c+%0d {step_en,busy,done,x} got=%b want=%b", j,
                 {bus.step_en, bus.busy, bus.done, bus.x}, {exp_step, exp_busy, exp_done, exp_x});
      end
      cyc();
    end
    bus.step_req = 1'b0;
    total++;
    if (bus.z_log !== m[3:0]) begin
      bad++;
      $display("FAIL auto_zlog got=%b want=%b", bus.z_log, m[3:0]);
    end
    my1 = m[5];
    my2 = m[4];
  endtask

  task automatic test_manual();
    logic [3:0] pat;
    logic [5:0] m;
    logic req, exp_step, exp_busy, exp_done, exp_x;
    int k;
    pat = 4'b0110;
    fsm_reset();
    m = model(pat, 4, my1, my2);
    bus.pattern = pat;
    bus.mode    = 1'b1;
    bus.start   = 1'b1;
    cyc();
    bus.start   = 1'b0;
    bus.mode    = 1'b0;
    bus.pattern = 4'b1111;
    k = 0;
    for (int j = 1; j <= 21; j++) begin
      req = (j == 3) || (j == 13) || (j == 14) || (j == 19) || (j == 20);
      bus.step_req = req;
      #1;
      exp_busy = (j <= 19);
      exp_step = req && exp_busy;
      exp_done = (j == 20);
      exp_x    = exp_busy ? pat[k] : 1'b0;
      total++;
      if ({bus.step_en, bus.busy, bus.done, bus.x} !== {exp_step, exp_busy, exp_done, exp_x}) begin
        bad++;
        $display("FAIL manual cyc=c+%0d {step_en,busy,done,x} got=%b want=%b", j,
                 {bus.step_en, bus.busy, bus.done, bus.x}, {exp_step, exp_busy, exp_done, exp_x});
      end
      if (exp_step && k < 3) k++;
      cyc();
    end
    bus.step_req = 1'b0;
    total++;
    if (bus.z_log !== m[3:0]) begin
      bad++;
      $display("FAIL manual_zlog got=%b want=%b", bus.z_log, m[3:0]);
    end
    my1 = m[5];
    my2 = m[4];
  endtask

  task automatic test_start_ignored();
    logic [3:0] pat;
    logic [5:0] m;
    logic exp_step, exp_busy, exp_done, exp_x;
    int k;
    pat = 4'b1011;
    fsm_reset();
    m = model(pat, 4, my1, my2);
    bus.pattern = pat;
    bus.mode    = 1'b0;
    bus.start   = 1'b1;
    cyc();
    bus.start = 1'b0;
    for (int j = 1; j <= 18; j++) begin
      bus.start   = (j == 6);
      if (j == 6) begin
        bus.pattern = 4'b0000;
        bus.mode    = 1'b1;
      end
      #1;
      exp_busy = (j <= 16);
      exp_step = exp_busy && (j % 4 == 0);
      exp_done = (j == 17);
      k        = exp_busy ? (j - 1) / 4 : 0;
      exp_x    = exp_busy ? pat[k] : 1'b0;
      total++;
      if ({bus.step_en, bus.busy, bus.done, bus.x} !== {exp_step, exp_busy, exp_done, exp_x}) begin
        bad++;
        $display("FAIL restart cyc=c+%0d {step_en,busy,done,x} got=%b want=%b", j,
                 {bus.step_en, bus.busy, bus.done, bus.x}, {exp_step, exp_busy, exp_done, exp_x});
      end
      cyc();
    end
    bus.mode = 1'b0;
    total++;
    if (bus.z_log !== m[3:0]) begin
      bad++;
      $display("FAIL restart_zlog got=%b want=%b", bus.z_log, m[3:0]);
    end
    my1 = m[5];
    my2 = m[4];
  endtask

  task automatic test_clr_midrun();
    logic [3:0] pat;
    logic [5:0] m;
    logic exp_step, exp_busy, exp_done;
    pat = 4'b1011;
    // FSM flops deliberately left in their previous state so z=1 gets logged early.
    m = model(pat, 2, my1, my2);
    bus.pattern = pat;
    bus.mode    = 1'b0;
    bus.start   = 1'b1;
    cyc();
    bus.start = 1'b0;
    for (int j = 1; j <= 9; j++) begin
      #1;
      total++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        bad++;
        $display("FAIL clr_prerun cyc=c+%0d busy=%b done=%b want 1 0", j, bus.busy, bus.done);
      end
      if (j == 9) begin
        total++;
        if (bus.z_log !== m[3:0]) begin
          bad++;
          $display("FAIL clr_pre_zlog got=%b want=%b", bus.z_log, m[3:0]);
        end
        clr = 1'b1;
      end
      cyc();
    end
    clr = 1'b0;
    my1 = m[5];
    my2 = m[4];
    for (int j = 10; j <= 20; j++) begin
      #1;
      total++;
      if ({bus.busy, bus.done, bus.step_en, bus.x} !== 4'b0000 || bus.z_log !== 4'b0000) begin
        bad++;
        $display("FAIL clr_after cyc=c+%0d {busy,done,step_en,x}=%b z_log=%b want 0000 0000", j,
                 {bus.busy, bus.done, bus.step_en, bus.x}, bus.z_log);
      end
      cyc();
    end
    pat = 4'b0101;
    m = model(pat, 4, my1, my2);
    bus.pattern = pat;
    bus.start   = 1'b1;
    cyc();
    bus.start = 1'b0;
    for (int j = 1; j <= 18; j++) begin
      #1;
      exp_busy = (j <= 16);
      exp_step = exp_busy && (j % 4 == 0);
      exp_done = (j == 17);
      total++;
      if ({bus.step_en, bus.busy, bus.done} !== {exp_step, exp_busy, exp_done}) begin
        bad++;
        $display("FAIL clr_rerun cyc=c+%0d {step_en,busy,done} got=%b want=%b", j,
                 {bus.step_en, bus.busy, bus.done}, {exp_step, exp_busy, exp_done});
      end
      cyc();
    end
    total++;
    if (bus.z_log !== m[3:0]) begin
      bad++;
      $display("FAIL clr_rerun_zlog got=%b want=%b", bus.z_log, m[3:0]);
    end
    my1 = m[5];
    my2 = m[4];
  endtask

  task automatic test_back_to_back();
    logic [5:0] m1, m2;
    logic exp_step, exp_busy, exp_done;
    int r;
    fsm_reset();
    m1 = model(4'b1011, 4, my1, my2);
    m2 = model(4'b0110, 4, m1[5], m1[4]);
    bus.pattern = 4'b1011;
    bus.mode    = 1'b0;
    bus.start   = 1'b1;
    cyc();
    for (int j = 1; j <= 37; j++) begin
      if (j == 10) bus.pattern = 4'b0110;
      if (j == 35) bus.start = 1'b0;
      #1;
      exp_busy = ((j >= 1) && (j <= 16)) || ((j >= 19) && (j <= 34));
      r        = (j <= 16) ? j : j - 18;
      exp_step = exp_busy && (r % 4 == 0);
      exp_done = (j == 17) || (j == 35);
      total++;
      if ({bus.step_en, bus.busy, bus.done} !== {exp_step, exp_busy, exp_done}) begin
        bad++;
        $display("FAIL b2b cyc=c+%0d {step_en,busy,done} got=%b want=%b", j,
                 {bus.step_en, bus.busy, bus.done}, {exp_step, exp_busy, exp_done});
      end
      if (j == 18) begin
        total++;
        if (bus.z_log !== m1[3:0]) begin
          bad++;
          $display("FAIL b2b_zlog1 got=%b want=%b", bus.z_log, m1[3:0]);
        end
      end
      if (j == 36) begin
        total++;
        if (bus.z_log !== m2[3:0]) begin
          bad++;
          $display("FAIL b2b_zlog2 got=%b want=%b", bus.z_log, m2[3:0]);
        end
      end
      cyc();
    end
    my1 = m2[5];
    my2 = m2[4];
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    clr          = 1'b1;
    fsm_clr      = 1'b1;
    my1          = 1'b0;
    my2          = 1'b0;
    bus.start    = 1'b0;
    bus.mode     = 1'b0;
    bus.step_req = 1'b0;
    bus.pattern  = 4'b0000;
    cyc();
    fsm_clr = 1'b0;
    test_reset();
    test_auto();
    test_manual();
    test_start_ignored();
    test_clr_midrun();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
